amm_pipeline_bridge: RTL
========================

# amm_pipeline_bridge

Registered Avalon-MM pipeline stage between the memory checker's master port (transmitter output) and the external memory slave. It cuts the combinational waitrequest path with a two-entry skid buffer, registers the read-response path, and caps outstanding read words so that the downstream controller's response queue cannot overflow. A busy flag lets the control logic wait for the memory path to drain before reporting test completion.

## Interface
- AMM_ADDR_W, rtl_settings_pkg::AMM_ADDR_W, address width
- AMM_DATA_W, rtl_settings_pkg::AMM_DATA_W, data width
- AMM_BURST_W, rtl_settings_pkg::AMM_BURST_W, burstcount width
- DATA_B_W, rtl_settings_pkg::DATA_B_W, byteenable width
- MAX_RD_WORDS, 64, maximum outstanding read words; must be ≥ 2^(AMM_BURST_W-1)

One clock; reset is synchronous and active-high.

- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- s_address_i / s_read_i / s_write_i / s_writedata_i / s_burstcount_i / s_byteenable_i  in  AMM_ADDR_W/1/1/AMM_DATA_W/AMM_BURST_W/DATA_B_W  upstream command
- s_waitrequest_o  out  1  upstream stall, registered
- s_readdata_o  out  AMM_DATA_W  registered read data
- s_readdatavalid_o  out  1  registered read valid
- m_address_o / m_read_o / m_write_o / m_writedata_o / m_burstcount_o / m_byteenable_o  out  same widths  downstream command, registered
- m_waitrequest_i  in  1  downstream stall
- m_readdata_i  in  AMM_DATA_W  downstream read data
- m_readdatavalid_i  in  1  downstream read valid
- busy_o  out  1  any command buffered or any read word outstanding
- rd_unexp_o  out  1  sticky: readdatavalid seen with zero outstanding words

## Operation
- Upstream accept condition: (s_read_i | s_write_i) & !s_waitrequest_o. Inputs are ignored while rst_i is high.
- Buffer holds two registers, MAIN and SKID, each with a valid bit. MAIN drives m_*; m_read_o / m_write_o = MAIN valid & type & !hold.
- hold is high only for a read in MAIN when rd_pend + m_burstcount_o > MAX_RD_WORDS. Writes are never held, so write bursts are never split or throttled.
- MAIN drain: MAIN valid & !hold & !m_waitrequest_i.
- Each cycle, MAIN loads when it is empty or draining:
  - from SKID if SKID is valid (SKID then clears, or reloads from an accepted input);
  - otherwise from an accepted input.
- An accepted input while MAIN is full and not draining goes to SKID.
- s_waitrequest_o is the next-state value of SKID valid, registered. A SKID overwrite can therefore never occur.
- rd_pend counter, width $clog2(MAX_RD_WORDS+1):
  - +burstcount on a read drain;
  - −1 on m_readdatavalid_i;
  - both in one cycle: net +burstcount−1.
  - A read burstcount of 0 is treated as 1.
- Underflow (m_readdatavalid_i with rd_pend = 0): rd_pend stays 0 and rd_unexp_o sets. rd_unexp_o clears only on reset.
- The read path registers m_readdata_i / m_readdatavalid_i into s_readdata_o / s_readdatavalid_o unconditionally; there is no backpressure.
- busy_o = MAIN valid | SKID valid | (rd_pend != 0), registered.

## Timing
- Reset values: all m_* = 0, s_waitrequest_o = 0, s_readdatavalid_o = 0, s_readdata_o = 0, busy_o = 0, rd_unexp_o = 0, rd_pend = 0, both buffer valids 0.
- A reset mid-burst discards MAIN, SKID and rd_pend without completing the burst.
- Command latency: a command accepted in cycle N appears on m_* in N+1 when MAIN is empty or draining in N.
- Throughput: 1 command per cycle with m_waitrequest_i low.
- Read data latency: exactly 1 cycle.
- s_waitrequest_o rises the cycle after SKID fills and falls the cycle after SKID empties.
- The hold check uses rd_pend registered before this cycle's decrement, which is conservative. A held read re-evaluates every cycle.

## Structure
- Package: MAX_RD_WORDS default constant goes into rtl_settings_pkg next to AMM_* widths. Also add a shared amm_cmd_t packed struct (address, read, write, writedata, burstcount, byteenable), used by MAIN/SKID.
- Sub-module: amm_cmd_skid, the generic two-register skid buffer on amm_cmd_t with valid/ready. The hold/rd_pend logic lives in the top.

## Test plan
- Single write, m_waitrequest_i = 0: s_write_i at N with address 0x10 → m_write_o = 1, m_address_o = 0x10 at N+1 only; busy_o = 1 at N+1, then 0.
- Waitrequest stall: m_waitrequest_i = 1 for 5 cycles while 4 back-to-back writes are offered.
  - s_waitrequest_o rises after the 2nd is accepted.
  - All 4 reach m_* in order, none lost or duplicated.
- Outstanding cap, MAX_RD_WORDS = 64:
  - read burst 64 issued → next read burst 1 held (m_read_o = 0);
  - 1 readdatavalid → held read issues next cycle.
- Simultaneous issue and return: read burst 8 drains in the same cycle as one readdatavalid with rd_pend = 3 → rd_pend = 10.
- Read data path: m_readdatavalid_i pulses with data 0xA5..A5 at N → s_readdatavalid_o / s_readdata_o = 0xA5..A5 at N+1.
- Unexpected data: readdatavalid with rd_pend = 0 → rd_unexp_o = 1 and stays 1 until rst_i. Apply rst_i mid-burst → all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/rtl_settings_pkg.sv
// Shared Avalon-MM widths, limits and the command bundle
// used by the memory-checker pipeline stages.
package rtl_settings_pkg;

  localparam int AMM_ADDR_W   = 27;
  localparam int AMM_DATA_W   = 64;
  localparam int AMM_BURST_W  = 7;
  localparam int DATA_B_W     = 8;
  localparam int MAX_RD_WORDS = 64;

  typedef struct packed {
    logic [AMM_ADDR_W-1:0]  address;
    logic                   read;
    logic                   write;
    logic [AMM_DATA_W-1:0]  writedata;
    logic [AMM_BURST_W-1:0] burstcount;
    logic [DATA_B_W-1:0]    byteenable;
  } amm_cmd_t;

  // A burstcount of zero still moves one word.
  function automatic logic [AMM_BURST_W:0] burst_words(
    input logic [AMM_BURST_W-1:0] bc
  );
    if (bc == '0) return (AMM_BURST_W+1)'(1);
    return {1'b0, bc};
  endfunction

endpackage

// File: rtl/amm_pipeline_bridge_if.sv
// Avalon-MM pipelined bus bundle with master/slave views.
// Command flows master->slave, waitrequest/read data flow back.
interface amm_pipeline_bridge_if #(
  parameter int AMM_ADDR_W  = rtl_settings_pkg::AMM_ADDR_W,
  parameter int AMM_DATA_W  = rtl_settings_pkg::AMM_DATA_W,
  parameter int AMM_BURST_W = rtl_settings_pkg::AMM_BURST_W,
  parameter int DATA_B_W    = rtl_settings_pkg::DATA_B_W
);

  logic [AMM_ADDR_W-1:0]  address;
  logic                   read;
  logic                   write;
  logic [AMM_DATA_W-1:0]  writedata;
  logic [AMM_BURST_W-1:0] burstcount;
  logic [DATA_B_W-1:0]    byteenable;
  logic                   waitrequest;
  logic [AMM_DATA_W-1:0]  readdata;
  logic                   readdatavalid;

  modport master (
    output address, read, write, writedata,
    output burstcount, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    input  burstcount, byteenable,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/amm_cmd_skid.sv
// Two-register (MAIN + SKID) buffer on amm_cmd_t.
// in_ready is the registered inverse of SKID valid.
module amm_cmd_skid
  import rtl_settings_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     in_valid_i,
  input  amm_cmd_t in_cmd_i,
  output logic     in_ready_o,
  output logic     out_valid_o,
  output amm_cmd_t out_cmd_o,
  input  logic     out_ready_i,
  output logic     nxt_valid_o
);

  logic     main_v_q, main_v_d;
  logic     skid_v_q, skid_v_d;
  amm_cmd_t main_q, main_d;
  amm_cmd_t skid_q, skid_d;
  logic     accept;
  logic     load;

  always_comb begin
    accept   = in_valid_i & ~skid_v_q;
    load     = ~main_v_q | out_ready_i;
    main_v_d = main_v_q;
    main_d   = main_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (load) begin
      if (skid_v_q) begin
        main_v_d = 1'b1;
        main_d   = skid_q;
        skid_v_d = accept;
        if (accept) skid_d = in_cmd_i;
      end else begin
        main_v_d = accept;
        if (accept) main_d = in_cmd_i;
      end
    end else if (accept) begin
      skid_v_d = 1'b1;
      skid_d   = in_cmd_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

  assign in_ready_o  = ~skid_v_q;
  assign out_valid_o = main_v_q;
  assign out_cmd_o   = main_q;
  assign nxt_valid_o = main_v_d | skid_v_d;

endmodule

// File: rtl/amm_pipeline_bridge.sv
// Registered Avalon-MM stage: skid-buffered command path,
// registered read path and an outstanding-read-word cap.
module amm_pipeline_bridge
  import rtl_settings_pkg::*;
#(
  parameter int AMM_ADDR_W   = rtl_settings_pkg::AMM_ADDR_W,
  parameter int AMM_DATA_W   = rtl_settings_pkg::AMM_DATA_W,
  parameter int AMM_BURST_W  = rtl_settings_pkg::AMM_BURST_W,
  parameter int DATA_B_W     = rtl_settings_pkg::DATA_B_W,
  parameter int MAX_RD_WORDS = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  amm_pipeline_bridge_if.slave  s,
  amm_pipeline_bridge_if.master m,
  output logic busy_o,
  output logic rd_unexp_o
);

  localparam int PW = $clog2(MAX_RD_WORDS + 1);

  logic [AMM_ADDR_W-1:0]  s_addr;
  logic [DATA_B_W-1:0]    s_be;
  logic [AMM_BURST_W:0]   words;
  amm_cmd_t               in_cmd;
  amm_cmd_t               main_cmd;
  logic                   in_ready;
  logic                   main_v;
  logic                   nxt_v;
  logic                   hold;
  logic                   out_ready;
  logic                   rd_drain;
  logic                   rd_dec;
  logic [PW-1:0]          rd_pend_q, rd_pend_d;
  logic                   busy_q, busy_d;
  logic                   unexp_q, unexp_d;
  logic                   rdv_q, rdv_d;
  logic [AMM_DATA_W-1:0]  rdata_q, rdata_d;

  assign s_addr = s.address;
  assign s_be   = s.byteenable;

  always_comb begin
    in_cmd            = '0;
    in_cmd.address    = s_addr;
    in_cmd.read       = s.read;
    in_cmd.write      = s.write;
    in_cmd.writedata  = s.writedata;
    in_cmd.burstcount = s.burstcount;
    in_cmd.byteenable = s_be;
  end

  amm_cmd_skid u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (s.read | s.write),
    .in_cmd_i    (in_cmd),
    .in_ready_o  (in_ready),
    .out_valid_o (main_v),
    .out_cmd_o   (main_cmd),
    .out_ready_i (out_ready),
    .nxt_valid_o (nxt_v)
  );

  // Hold uses the pre-decrement count, so it is conservative.
  always_comb begin
    words     = burst_words(main_cmd.burstcount);
    hold      = main_v & main_cmd.read &
                (32'(rd_pend_q) + 32'(words) >
                 32'(MAX_RD_WORDS));
    out_ready = ~hold & ~m.waitrequest;
    rd_drain  = main_v & main_cmd.read & out_ready;
    rd_dec    = m.readdatavalid & (rd_pend_q != '0);
    rd_pend_d = rd_pend_q
              + (rd_drain ? PW'(words) : '0)
              - (rd_dec ? PW'(1) : '0);
    unexp_d   = unexp_q |
                (m.readdatavalid & (rd_pend_q == '0));
    busy_d    = nxt_v | (rd_pend_d != '0);
    rdv_d     = m.readdatavalid;
    rdata_d   = m.readdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_pend_q <= '0;
      busy_q    <= 1'b0;
      unexp_q   <= 1'b0;
      rdv_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      busy_q    <= busy_d;
      unexp_q   <= unexp_d;
      rdv_q     <= rdv_d;
      rdata_q   <= rdata_d;
    end
  end

  assign m.address    = main_cmd.address;
  assign m.writedata  = main_cmd.writedata;
  assign m.burstcount = main_cmd.burstcount;
  assign m.byteenable = main_cmd.byteenable;
  assign m.read       = main_v & main_cmd.read & ~hold;
  assign m.write      = main_v & main_cmd.write & ~hold;

  assign s.waitrequest   = ~in_ready;
  assign s.readdata      = rdata_q;
  assign s.readdatavalid = rdv_q;
  assign busy_o          = busy_q;
  assign rd_unexp_o      = unexp_q;

endmodule
